// File: rtl/des_out_misr.sv
// des_out_misr: folds the 64-bit cipher output into a 32-bit MISR after a warmup interval
// and publishes one signature per fixed window of enabled samples.
module des_out_misr #(
  parameter int DATA_W = 64,
  parameter int SIG_W = 32,
  parameter int WARMUP = 48,
  parameter int WINDOW = 1024,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  signature,
  output logic              sig_valid,
  output logic [15:0]       window_count,
  output logic              busy
);
  localparam logic WARM = 1'b0;
  localparam logic ACCUM = 1'b1;
  localparam logic RST_STATE = (WARMUP == 0) ? ACCUM : WARM;
  localparam logic [16:0] WARM_LAST = 17'(WARMUP - 1);
  localparam logic [16:0] WIN_LAST = 17'(WINDOW - 1);
  logic state, state_d, warm_done, done;
  logic [16:0] warm_cnt, samp_cnt;
  logic [SIG_W-1:0] misr, nxt, folded;
  always_comb begin
    folded = data_in[DATA_W-1:SIG_W] ^ data_in[SIG_W-1:0];
    nxt = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ folded;
    warm_done = enable && state == WARM && warm_cnt == WARM_LAST;
    done = enable && state == ACCUM && samp_cnt == WIN_LAST;
    state_d = warm_done ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_STATE;
      warm_cnt <= '0;
      samp_cnt <= '0;
      misr <= SEED;
      signature <= '0;
      sig_valid <= 1'b0;
      window_count <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      busy <= state_d == ACCUM;
      sig_valid <= done;
      if (enable && state == WARM) warm_cnt <= warm_cnt + 17'd1;
      if (enable && state == ACCUM) begin
        misr <= done ? SEED : nxt;
        samp_cnt <= done ? '0 : samp_cnt + 17'd1;
      end
      if (done) begin
        signature <= nxt;
        window_count <= window_count + {15'd0, window_count != 16'hFFFF};
      end
    end
  end
endmodule

// File: doc/des_out_misr.md
Name: des_out_misr

Overview:
- Downstream compaction stage for the out-of-core 3DES performance design.
- Consumes the 64-bit cipher output every clock and folds it into a 32-bit multiple-input signature register (MISR).
- Skips the pipeline-fill interval and publishes one signature per fixed window of samples.
- Keeps every cipher output bit observable to implementation while exposing only a small output set, so bitstream generation cannot trim the cipher core.

Parameters:
- DATA_W, 64: width of data_in; must be even.
- SIG_W, 32: signature width; must equal DATA_W/2.
- WARMUP, 48: enabled cycles discarded after reset before accumulation starts; legal range 0..65535.
- WINDOW, 1024: samples per signature; legal range 1..65536.
- POLY, 32'h04C11DB7: MISR feedback polynomial.
- SEED, 32'hFFFFFFFF: MISR value after reset and after each window.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- enable  in  1  sample qualifier; when low, all state holds.
- data_in  in  DATA_W  cipher output word, sampled every enabled cycle.
- signature  out  SIG_W  last completed window signature.
- sig_valid  out  1  one-cycle pulse when signature updates.
- window_count  out  16  completed windows; saturates at 16'hFFFF.
- busy  out  1  high while in ACCUM.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WARM, or ACCUM if WARMUP=0.
  - warm_cnt=0, samp_cnt=0, misr=SEED.
  - signature=0, sig_valid=0, window_count=0, busy=0.
- Fold: folded = data_in[DATA_W-1:SIG_W] ^ data_in[SIG_W-1:0].
- MISR step: next = {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ folded.
- State WARM:
  - On each enabled edge, warm_cnt increments and data_in is ignored.
  - The edge on which warm_cnt reaches WARMUP-1 moves to ACCUM.
  - So exactly WARMUP samples are discarded.
- State ACCUM:
  - On each enabled edge, misr <= next and samp_cnt increments.
  - On the edge where samp_cnt = WINDOW-1 (window complete):
    - signature <= next, including that sample.
    - sig_valid <= 1; it is 0 on every other edge.
    - misr <= SEED and samp_cnt <= 0.
    - window_count increments unless saturated.
  - Windows are back-to-back with no gap cycles.
  - Latency: signature and sig_valid are visible the cycle after the edge that absorbed the final sample.
- enable=0:
  - warm_cnt, samp_cnt, misr, state and window_count hold.
  - sig_valid drives 0.
  - A window spanning a pause yields the same signature as the same samples applied contiguously.
- busy = (state==ACCUM), registered.
- No terminal state; the block never leaves ACCUM except via reset.
- Reset asserted mid-window: the partial MISR is discarded, and the warmup interval is repeated after release.
- Internal counters are 17 bits so WINDOW=65536 works without wrap.

Test Plan:
- WARMUP=2, WINDOW=1, data_in=0, enable=1 from reset release:
  - sig_valid pulses exactly once per cycle from the 4th edge on.
  - first signature=32'hFB3EE249; window_count=1 after the first pulse.
- WARMUP=2, WINDOW=1, data_in=64'h0000_0000_0000_0001:
  - first signature=32'hFB3EE248.
  - data_in=64'h0000_0001_0000_0001 instead gives 32'hFB3EE249, because the fold cancels.
- WARMUP=48, WINDOW=4, random data with enable toggling pseudo-randomly:
  - signatures match a reference model fed only the enabled samples.
  - no sig_valid pulse while enable=0.
  - first pulse never before 52 enabled edges.
- WINDOW=4, reset driven low asynchronously mid-cycle after 2 accumulated samples:
  - all outputs clear immediately.
  - after release, WARMUP samples are discarded again.
  - the next signature equals that of a fresh run.
- WARMUP=0, WINDOW=1, 65537 enabled edges:
  - window_count reaches 16'hFFFF and stays there.
  - sig_valid keeps pulsing every cycle.
- WINDOW=3, data constant 64'hDEAD_BEEF_0123_4567:
  - consecutive signatures are identical, confirming reseed to SEED between windows.
